// File: rtl/spsram_bist.sv
// Built-in self-test engine for the single-port synchronous SRAM: writes a
// selected pattern to every address, reads everything back and scores it.
module spsram_bist #(
   parameter int BW_DATA = 32,
   parameter int BW_ADDR = 5,
   parameter int RD_LAT  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [1:0]         i_pattern_sel,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_pass,
   output logic [BW_ADDR:0]   o_err_cnt,
   output logic [BW_ADDR-1:0] o_first_err_addr,
   output logic               o_sram_cen,
   output logic               o_sram_wen,
   output logic               o_sram_oen,
   output logic [BW_ADDR-1:0] o_sram_addr,
   output logic [BW_DATA-1:0] o_sram_wdata,
   input  logic [BW_DATA-1:0] i_sram_rdata
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

   localparam logic [BW_ADDR-1:0] LAST_ADDR  = '1;
   localparam logic [BW_ADDR-1:0] DRAIN_LAST = BW_ADDR'(RD_LAT - 1);
   localparam logic [BW_ADDR-1:0] ADDR_ONE   = BW_ADDR'(1);
   localparam logic [BW_ADDR:0]   CNT_ONE    = (BW_ADDR + 1)'(1);

   state_t             state, next;
   logic [BW_ADDR-1:0] cnt;
   logic [1:0]         pat_sel;
   logic [BW_ADDR:0]   err_cnt;
   logic [BW_ADDR-1:0] first_err;
   logic               pass_q;
   logic               dl_vld  [RD_LAT];
   logic [BW_ADDR-1:0] dl_addr [RD_LAT];

   function automatic logic [BW_DATA-1:0] pat(input logic [1:0] sel,
                                              input logic [BW_ADDR-1:0] a);
      logic [BW_DATA-1:0] az;
      logic [BW_DATA-1:0] aa;
      az = BW_DATA'(a);
      for (int unsigned i = 0; i < BW_DATA; i++) aa[i] = i[0];
      case (sel)
         2'd0:    pat = az;
         2'd1:    pat = ~az;
         2'd2:    pat = a[0] ? ~aa : aa;
         default: pat = '1;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   always_comb begin
      next         = state;
      o_sram_cen   = 1'b0;
      o_sram_wen   = 1'b0;
      o_sram_oen   = 1'b0;
      o_sram_addr  = '0;
      o_sram_wdata = '0;
      case (state)
         IDLE: if (i_start) next = WRITE;
         WRITE: begin
            o_sram_cen   = 1'b1;
            o_sram_wen   = 1'b1;
            o_sram_addr  = cnt;
            o_sram_wdata = pat(pat_sel, cnt);
            if (cnt == LAST_ADDR) next = READ;
         end
         READ: begin
            o_sram_cen  = 1'b1;
            o_sram_oen  = 1'b1;
            o_sram_addr = cnt;
            if (cnt == LAST_ADDR) next = DRAIN;
         end
         DRAIN: begin
            o_sram_oen = 1'b1;
            if (cnt == DRAIN_LAST) next = DONE;
         end
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         pat_sel   <= '0;
         err_cnt   <= '0;
         first_err <= '0;
         pass_q    <= 1'b0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            dl_vld[i]  <= 1'b0;
            dl_addr[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            dl_vld[i]  <= dl_vld[i-1];
            dl_addr[i] <= dl_addr[i-1];
         end
         dl_vld[0]  <= (state == READ);
         dl_addr[0] <= cnt;

         case (state)
            IDLE: if (i_start) begin
               cnt       <= '0;
               pat_sel   <= i_pattern_sel;
               err_cnt   <= '0;
               first_err <= '0;
               pass_q    <= 1'b0;
            end
            WRITE, READ: cnt <= cnt + ADDR_ONE;
            // cnt is reused as the drain timer and is left at 0 for the next run
            DRAIN: cnt <= (cnt == DRAIN_LAST) ? '0 : cnt + ADDR_ONE;
            DONE:  pass_q <= (err_cnt == '0);
            default: ;
         endcase

         if (dl_vld[RD_LAT-1] &&
             (i_sram_rdata != pat(pat_sel, dl_addr[RD_LAT-1]))) begin
            err_cnt <= err_cnt + CNT_ONE;
            if (err_cnt == '0) first_err <= dl_addr[RD_LAT-1];
         end
      end
   end

   assign o_busy           = (state != IDLE);
   assign o_done           = (state == DONE);
   assign o_pass           = (state == DONE) ? (err_cnt == '0) : pass_q;
   assign o_err_cnt        = err_cnt;
   assign o_first_err_addr = first_err;

endmodule

// File: tb/tb_spsram_bist.sv
// Directed bench for spsram_bist: RD_LAT=1 instance with a fault-injectable
// SRAM model, plus an RD_LAT=2 instance with a two-stage SRAM model.
module tb_spsram_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic        rst;
   logic [1:0]  pattern;
   logic        start1, start2, inject;

   logic        busy1, done1, pass1, cen1, wen1, oen1;
   logic [5:0]  err1;
   logic [4:0]  first1, addr1;
   logic [31:0] wdata1, rdata1;

   logic        busy2, done2, pass2, cen2, wen2, oen2;
   logic [5:0]  err2;
   logic [4:0]  first2, addr2;
   logic [31:0] wdata2, rdata2, stage2;

   logic [31:0] mem1 [32];
   logic [31:0] mem2 [32];

   spsram_bist #(.BW_DATA(32), .BW_ADDR(5), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .i_start(start1), .i_pattern_sel(pattern),
      .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_cnt(err1),
      .o_first_err_addr(first1), .o_sram_cen(cen1), .o_sram_wen(wen1),
      .o_sram_oen(oen1), .o_sram_addr(addr1), .o_sram_wdata(wdata1),
      .i_sram_rdata(rdata1));

   spsram_bist #(.BW_DATA(32), .BW_ADDR(5), .RD_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .i_start(start2), .i_pattern_sel(pattern),
      .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_err_cnt(err2),
      .o_first_err_addr(first2), .o_sram_cen(cen2), .o_sram_wen(wen2),
      .o_sram_oen(oen2), .o_sram_addr(addr2), .o_sram_wdata(wdata2),
      .i_sram_rdata(rdata2));

   // Bit 0 of cells 5 and 9 reads back stuck at 1 while inject is set
   always @(posedge clk) begin
      if (cen1 && wen1) mem1[addr1] <= wdata1;
      if (cen1 && !wen1)
         rdata1 <= (inject && (addr1 == 5'd5 || addr1 == 5'd9)) ?
                   (mem1[addr1] | 32'h1) : mem1[addr1];
   end

   always @(posedge clk) begin
      if (cen2 && wen2) mem2[addr2] <= wdata2;
      if (cen2 && !wen2) stage2 <= mem2[addr2];
      rdata2 <= stage2;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag, input bit which);
      if (!which)
         check(tag, {busy1, done1, pass1, err1, first1, cen1, wen1, oen1, addr1},
               32'h0);
      else
         check(tag, {busy2, done2, pass2, err2, first2, cen2, wen2, oen2, addr2},
               32'h0);
      check({tag, "_wdata"}, which ? wdata2 : wdata1, 32'h0);
   endtask

   // Start on edge 0, then observe cycles 1..199 (#1 after each edge)
   task automatic run(input bit which, input logic [1:0] p, input int restart_at,
                      output int done_cyc, output int n_done,
                      output logic [31:0] w3, output logic [31:0] w1);
      int cyc;
      pattern = p;
      done_cyc = 0; n_done = 0; w3 = 'x; w1 = 'x;
      @(negedge clk);
      if (which) start2 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; start2 = 1'b0;
      check("busy_cycle1", which ? busy2 : busy1, 1);
      for (cyc = 1; cyc < 200; cyc++) begin
         if ((which ? cen2 : cen1) && (which ? wen2 : wen1)) begin
            if ((which ? addr2 : addr1) == 5'd3) w3 = which ? wdata2 : wdata1;
            if ((which ? addr2 : addr1) == 5'd1) w1 = which ? wdata2 : wdata1;
         end
         if (which ? done2 : done1) begin
            n_done++;
            if (done_cyc == 0) done_cyc = cyc;
         end
         if (cyc == restart_at) begin
            if (which) start2 = 1'b1; else start1 = 1'b1;
         end else begin
            start1 = 1'b0; start2 = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   int          dc, nd, k;
   logic [31:0] w3, w1;

   initial begin
      rst = 1'b1; start1 = 1'b0; start2 = 1'b0; pattern = 2'd0; inject = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_quiet("reset_idle_lat1", 1'b0);
      check_quiet("reset_idle_lat2", 1'b1);

      // Pattern 0, fault-free
      run(1'b0, 2'd0, -1, dc, nd, w3, w1);
      check("p0_done_cycle", dc, 66);
      check("p0_done_count", nd, 1);
      check("p0_pass", pass1, 1);
      check("p0_err_cnt", err1, 0);
      check("p0_first_err", first1, 0);
      check("p0_wdata_addr3", w3, 32'h3);
      check("p0_idle_busy", busy1, 0);

      // Pattern 1 with stuck-at-1 bit 0 at addresses 5 and 9
      inject = 1'b1;
      run(1'b0, 2'd1, -1, dc, nd, w3, w1);
      inject = 1'b0;
      check("p1_wdata_addr3", w3, 32'hFFFF_FFFC);
      check("p1_done_cycle", dc, 66);
      check("p1_pass", pass1, 0);
      check("p1_err_cnt", err1, 2);
      check("p1_first_err", first1, 5);

      // Pattern 2 with a start re-pulse during READ (cycle 40)
      run(1'b0, 2'd2, 40, dc, nd, w3, w1);
      check("p2_done_count", nd, 1);
      check("p2_done_cycle", dc, 66);
      check("p2_pass", pass1, 1);
      check("p2_err_cnt", err1, 0);
      check("p2_wdata_addr1", w1, 32'h5555_5555);
      check("p2_wdata_addr3", w3, 32'h5555_5555);

      // Reset asserted while reading address 10
      pattern = 2'd0;
      @(negedge clk); start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      k = 0;
      while (!(cen1 && !wen1 && addr1 == 5'd10) && k < 200) begin
         @(posedge clk); #1 k++;
      end
      check("rst_reached_read10", (k < 200), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_quiet("rst_mid_read", 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_quiet("rst_stays_idle", 1'b0);

      run(1'b0, 2'd3, -1, dc, nd, w3, w1);
      check("p3_done_cycle", dc, 66);
      check("p3_pass", pass1, 1);
      check("p3_err_cnt", err1, 0);
      check("p3_wdata_addr3", w3, 32'hFFFF_FFFF);

      // RD_LAT=2 instance, pattern 0
      run(1'b1, 2'd0, -1, dc, nd, w3, w1);
      check("lat2_done_cycle", dc, 67);
      check("lat2_done_count", nd, 1);
      check("lat2_pass", pass2, 1);
      check("lat2_err_cnt", err2, 0);
      check("lat2_first_err", first2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/spsram_bist.md
# spsram_bist

Built-in self-test engine for the single-port synchronous SRAM (`spsram`). On a start pulse it drives the SRAM port itself: it writes a selected data pattern to every address, then reads every address back and compares each word against the expected value. It reports busy, done, pass/fail, error count and first failing address. It sits between the SRAM macro and the test/control logic, in place of the testbench-style stimulus driver.

## Interface

Parameters:
- `BW_DATA`, 32, SRAM data width.
- `BW_ADDR`, 5, SRAM address width; depth N = 2^BW_ADDR.
- `RD_LAT`, 1, SRAM read latency in cycles (legal 1..4). Read data is valid RD_LAT cycles after the cycle in which the read is presented.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_pattern_sel`  in  2  pattern select; latched on start.
- `o_busy`  out  1  high while not IDLE.
- `o_done`  out  1  one-cycle pulse in the DONE state.
- `o_pass`  out  1  result of the last run; held until the next start.
- `o_err_cnt`  out  BW_ADDR+1  number of mismatching reads in the last run.
- `o_first_err_addr`  out  BW_ADDR  address of the first mismatch; 0 if none.
- `o_sram_cen`  out  1  SRAM chip enable.
- `o_sram_wen`  out  1  SRAM write enable (1 = write).
- `o_sram_oen`  out  1  SRAM output enable.
- `o_sram_addr`  out  BW_ADDR  SRAM address.
- `o_sram_wdata`  out  BW_DATA  SRAM write data.
- `i_sram_rdata`  in  BW_DATA  SRAM read data.

## Operation

- States: IDLE, WRITE, READ, DRAIN, DONE. There is one address counter `cnt` (BW_ADDR bits).
- Reset: state IDLE and `cnt` = 0. All outputs are 0, including `o_pass`. The delay line is cleared.
- IDLE: if `i_start` = 1, go to WRITE, latch `i_pattern_sel`, and clear `cnt`, `o_err_cnt`, `o_first_err_addr` and `o_pass`.
- WRITE: drive `cen`=1, `wen`=1, `oen`=0, `addr`=`cnt`, `wdata`=pat(`cnt`), and increment `cnt`. When `cnt` = N-1, `cnt` wraps to 0 and the state goes to READ.
- READ: drive `cen`=1, `wen`=0, `oen`=1, `addr`=`cnt`, and push {valid, `cnt`} into an RD_LAT-deep delay line. When `cnt` = N-1, go to DRAIN.
- DRAIN: drive `cen`=0, `wen`=0, `oen`=1. Stay for exactly RD_LAT cycles, then go to DONE.
- DONE: all SRAM controls are 0 and `o_done`=1. `o_pass` is set to (`o_err_cnt` == 0). The next state is IDLE.
- Compare: when the delay-line output is valid, compare `i_sram_rdata` with pat(delayed addr). On a mismatch, increment `o_err_cnt`. If `o_err_cnt` was 0, also capture the delayed address into `o_first_err_addr`. The maximum count is N, so `o_err_cnt` never overflows.
- Patterns, where a = address zero-extended to BW_DATA:
  - 0: a
  - 1: ~a
  - 2: 0xAAAA_AAAA (truncated/replicated to BW_DATA) at even a, 0x5555_5555 at odd a
  - 3: all ones
- SRAM port outputs are combinational decodes of the state, `cnt` and the latched pattern select. Nothing is driven outside WRITE, READ and DRAIN.
- `i_start` while busy is ignored; it is not queued.
- `rst` mid-run returns the block to IDLE immediately. All outputs go to 0 and the partial results are discarded.

## Timing

- Take `i_start` sampled at edge 0.
- Write cycles are 1..N; SRAM writes commit at edges 1..N.
- Read cycles are N+1..2N.
- The read issued in cycle c is compared at the edge ending cycle c+RD_LAT.
- DRAIN occupies cycles 2N+1..2N+RD_LAT.
- `o_done` is high in cycle 2N+RD_LAT+1. With N=32 and RD_LAT=1 this is cycle 66.
- `o_busy` is high in cycles 1..2N+RD_LAT+1.
- `o_pass`, `o_err_cnt` and `o_first_err_addr` are final in the DONE cycle and hold through IDLE.
- The earliest accepted restart is `i_start` sampled in the first IDLE cycle after DONE.

## Test plan

- Reset, then idle for 5 cycles -> all outputs 0, `o_busy`=0, no SRAM activity.
- Pattern 0 against a fault-free behavioural SRAM (RD_LAT=1) -> writes data=addr to 0..31, then 32 reads. `o_done` pulses exactly 66 cycles after the start edge, with `o_pass`=1, `o_err_cnt`=0, `o_first_err_addr`=0.
- Pattern 1 with bit 0 stuck-at-1 injected at addresses 5 and 9 -> at addr 3, `wdata`=0xFFFF_FFFC. Result: `o_pass`=0, `o_err_cnt`=2, `o_first_err_addr`=5.
- Pattern 2 run, with `i_start` re-pulsed during READ -> the pulse is ignored, a single `o_done` is seen, and `o_pass`=1. An odd address is written with 0x5555_5555.
- `rst` asserted mid-READ (at addr 10) -> the next cycle shows all outputs 0 and IDLE. A new pattern 3 run then passes, with `o_err_cnt`=0.
- RD_LAT=2 build with a 2-cycle SRAM model, pattern 0 -> `o_done` at cycle 67 and `o_pass`=1.
